// File: rtl/fmac_stream_if.sv
// Stream bundle for fmac_stream: sample input stream, flush/threshold
// controls and the result output stream.
interface fmac_stream_if #(
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 16,
    parameter int COUNT_W = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  x;
    logic [DATA_W-1:0]  y;
    logic               last;
    logic               clear;
    logic [ACC_W-1:0]   threshold;
    logic               out_valid;
    logic               out_ready;
    logic [ACC_W-1:0]   a;
    logic [COUNT_W-1:0] out_count;
    logic               out_over;
    logic               out_ovf;

    // MAC side
    modport slave (
        input  in_valid, x, y, last, clear, threshold, out_ready,
        output in_ready, out_valid, a, out_count, out_over, out_ovf
    );

    // Source/consumer side
    modport master (
        output in_valid, x, y, last, clear, threshold, out_ready,
        input  in_ready, out_valid, a, out_count, out_over, out_ovf
    );
endinterface

// File: rtl/fmac_stream.sv
// Two-stage streaming multiply-accumulate. Stage 1 registers x*y, stage 2
// accumulates with optional saturation and emits a result on frame end or
// when the running sum exceeds the threshold.
module fmac_stream #(
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 16,
    parameter int SIGNED   = 0,
    parameter int SATURATE = 1,
    parameter int COUNT_W  = 8
) (
    input  logic          CLK,
    input  logic          RESET,
    fmac_stream_if.slave  bus
);
    localparam int PW = 2 * DATA_W;
    localparam int SW = ACC_W + 1;
    localparam logic [ACC_W-1:0]   U_MAX   = '1;
    localparam logic [ACC_W-1:0]   S_MAX   = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0]   S_MIN   = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    logic               s1_valid_q, s1_valid_d;
    logic [PW-1:0]      s1_p_q, s1_p_d;
    logic               s1_last_q, s1_last_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   a_q, a_d;
    logic [COUNT_W-1:0] out_count_q, out_count_d;
    logic               out_over_q, out_over_d;
    logic               out_ovf_q, out_ovf_d;

    logic               en;
    logic               hs;
    logic [PW-1:0]      prod;
    logic [ACC_W-1:0]   p_ext;
    logic [ACC_W:0]     sum;
    logic               ovf_now;
    logic [ACC_W-1:0]   sat_val;
    logic [ACC_W-1:0]   acc_next;
    logic [COUNT_W-1:0] cnt_next;
    logic               ovf_next;
    logic               exceed;

    // A held, unconsumed result freezes the whole pipe
    assign en            = !(out_valid_q && !bus.out_ready);
    assign bus.in_ready  = en && !bus.clear;
    assign hs            = bus.in_valid && bus.in_ready;

    assign bus.out_valid = out_valid_q;
    assign bus.a         = a_q;
    assign bus.out_count = out_count_q;
    assign bus.out_over  = out_over_q;
    assign bus.out_ovf   = out_ovf_q;

    // Product, extended sum, overflow detection, clamp/wrap and threshold compare
    always_comb begin
        prod    = '0;
        p_ext   = '0;
        sum     = '0;
        ovf_now = 1'b0;
        sat_val = '0;
        exceed  = 1'b0;
        if (SIGNED != 0) begin
            prod    = PW'($signed(bus.x)) * PW'($signed(bus.y));
            p_ext   = ACC_W'($signed(s1_p_q));
            sum     = SW'($signed(acc_q)) + SW'($signed(p_ext));
            // sum carries one guard bit, so its top bit is the true sign
            ovf_now = sum[ACC_W] ^ sum[ACC_W-1];
            sat_val = sum[ACC_W] ? S_MIN : S_MAX;
        end else begin
            prod    = PW'(bus.x) * PW'(bus.y);
            p_ext   = ACC_W'(s1_p_q);
            sum     = SW'(acc_q) + SW'(p_ext);
            ovf_now = sum[ACC_W];
            sat_val = U_MAX;
        end
        if (ovf_now && (SATURATE != 0)) begin
            acc_next = sat_val;
        end else begin
            acc_next = sum[ACC_W-1:0];
        end
        cnt_next = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        ovf_next = ovf_q | ovf_now;
        if (SIGNED != 0) begin
            exceed = $signed(acc_next) > $signed(bus.threshold);
        end else begin
            exceed = acc_next > bus.threshold;
        end
    end

    // Pipeline, accumulator and output register next-state
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_p_d      = s1_p_q;
        s1_last_d   = s1_last_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q && !bus.out_ready;
        a_d         = a_q;
        out_count_d = out_count_q;
        out_over_d  = out_over_q;
        out_ovf_d   = out_ovf_q;
        if (bus.clear) begin
            // flush wins over any emit this cycle; output register untouched
            s1_valid_d = 1'b0;
            acc_d      = '0;
            cnt_d      = '0;
            ovf_d      = 1'b0;
        end else if (en) begin
            s1_valid_d = hs;
            s1_p_d     = prod;
            s1_last_d  = bus.last;
            if (s1_valid_q) begin
                if (exceed || s1_last_q) begin
                    out_valid_d = 1'b1;
                    a_d         = acc_next;
                    out_count_d = cnt_next;
                    out_over_d  = exceed;
                    out_ovf_d   = ovf_next;
                    acc_d       = '0;
                    cnt_d       = '0;
                    ovf_d       = 1'b0;
                end else begin
                    acc_d = acc_next;
                    cnt_d = cnt_next;
                    ovf_d = ovf_next;
                end
            end
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            s1_valid_q  <= 1'b0;
            s1_p_q      <= '0;
            s1_last_q   <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            a_q         <= '0;
            out_count_q <= '0;
            out_over_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_p_q      <= s1_p_d;
            s1_last_q   <= s1_last_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            a_q         <= a_d;
            out_count_q <= out_count_d;
            out_over_q  <= out_over_d;
            out_ovf_q   <= out_ovf_d;
        end
    end
endmodule

// File: tb/tb_fmac_stream.sv
// Scoreboard bench for fmac_stream: three instances (unsigned/saturate,
// unsigned/wrap, signed/saturate) driven with directed vectors.
module tb_fmac_stream;
    logic CLK;
    logic RESET;

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  cnt;
        logic        over;
        logic        ovf;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int checks = 0;
    int errors = 0;
    int last_wait = 0;

    fmac_stream_if #(.DATA_W(8), .ACC_W(16), .COUNT_W(8)) if0 ();
    fmac_stream_if #(.DATA_W(8), .ACC_W(16), .COUNT_W(8)) if1 ();
    fmac_stream_if #(.DATA_W(8), .ACC_W(16), .COUNT_W(8)) if2 ();

    fmac_stream #(.DATA_W(8), .ACC_W(16), .SIGNED(0), .SATURATE(1), .COUNT_W(8))
        u_sat (.CLK(CLK), .RESET(RESET), .bus(if0.slave));
    fmac_stream #(.DATA_W(8), .ACC_W(16), .SIGNED(0), .SATURATE(0), .COUNT_W(8))
        u_wrap (.CLK(CLK), .RESET(RESET), .bus(if1.slave));
    fmac_stream #(.DATA_W(8), .ACC_W(16), .SIGNED(1), .SATURATE(1), .COUNT_W(8))
        u_sgn (.CLK(CLK), .RESET(RESET), .bus(if2.slave));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: run still active at 200000, required finish earlier");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic set_in(int idx, logic v, logic [7:0] xx, logic [7:0] yy, logic l);
        case (idx)
            0: begin if0.in_valid = v; if0.x = xx; if0.y = yy; if0.last = l; end
            1: begin if1.in_valid = v; if1.x = xx; if1.y = yy; if1.last = l; end
            default: begin if2.in_valid = v; if2.x = xx; if2.y = yy; if2.last = l; end
        endcase
    endtask

    function automatic logic in_rdy(int idx);
        case (idx)
            0: return if0.in_ready;
            1: return if1.in_ready;
            default: return if2.in_ready;
        endcase
    endfunction

    function automatic logic [31:0] outs(int idx);
        case (idx)
            0: return {5'b0, if0.out_valid, if0.a, if0.out_count, if0.out_over, if0.out_ovf};
            1: return {5'b0, if1.out_valid, if1.a, if1.out_count, if1.out_over, if1.out_ovf};
            default: return {5'b0, if2.out_valid, if2.a, if2.out_count, if2.out_over, if2.out_ovf};
        endcase
    endfunction

    task automatic push(int idx, logic [15:0] a, logic [7:0] c, logic ov, logic of);
        exp_t e;
        e = '{a: a, cnt: c, over: ov, ovf: of};
        case (idx)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    // Called at posedge+1; returns at posedge+1 after the handshake edge.
    task automatic send(int idx, logic [7:0] xx, logic [7:0] yy, logic l);
        int  n = 0;
        bit  done = 0;
        set_in(idx, 1'b1, xx, yy, l);
        while (!done) begin
            @(negedge CLK);
            done = in_rdy(idx);
            @(posedge CLK);
            #1;
            n++;
            if (!done && n > 50) begin
                checks++;
                errors++;
                $display("FAIL send_timeout dut%0d: in_ready low for %0d cycles, required handshake", idx, n);
                done = 1;
            end
        end
        last_wait = n;
        set_in(idx, 1'b0, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic wait_valid(int idx);
        int  n = 0;
        bit  seen = 0;
        while (!seen && n < 20) begin
            @(negedge CLK);
            seen = outs(idx)[26];
            n++;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL wait_valid dut%0d: out_valid still 0 after %0d cycles, required 1", idx, n);
        end
    endtask

    task automatic drain();
        repeat (5) @(posedge CLK);
        #1;
    endtask

    task automatic mon_check(int idx, logic [15:0] a, logic [7:0] c, logic ov, logic of);
        exp_t e;
        bit   have = 0;
        case (idx)
            0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1; end
        endcase
        checks++;
        if (!have) begin
            errors++;
            $display("FAIL unexpected_result dut%0d: got a=%h cnt=%0d over=%b ovf=%b, required no result",
                     idx, a, c, ov, of);
        end else if (a !== e.a || c !== e.cnt || ov !== e.over || of !== e.ovf) begin
            errors++;
            $display("FAIL result dut%0d: got a=%h cnt=%0d over=%b ovf=%b, expected a=%h cnt=%0d over=%b ovf=%b",
                     idx, a, c, ov, of, e.a, e.cnt, e.over, e.ovf);
        end
    endtask

    always @(negedge CLK)
        if (!RESET && if0.out_valid && if0.out_ready)
            mon_check(0, if0.a, if0.out_count, if0.out_over, if0.out_ovf);
    always @(negedge CLK)
        if (!RESET && if1.out_valid && if1.out_ready)
            mon_check(1, if1.a, if1.out_count, if1.out_over, if1.out_ovf);
    always @(negedge CLK)
        if (!RESET && if2.out_valid && if2.out_ready)
            mon_check(2, if2.a, if2.out_count, if2.out_over, if2.out_ovf);

    initial begin
        RESET = 1'b1;
        for (int i = 0; i < 3; i++) set_in(i, 1'b0, 8'h00, 8'h00, 1'b0);
        if0.clear = 1'b0; if1.clear = 1'b0; if2.clear = 1'b0;
        if0.threshold = 16'hFFFF; if1.threshold = 16'hFFFF; if2.threshold = 16'hFFFF;
        if0.out_ready = 1'b1; if1.out_ready = 1'b1; if2.out_ready = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset_state_sat", outs(0), 32'h0);
        chk("reset_state_sgn", outs(2), 32'h0);
        @(negedge CLK);
        RESET = 1'b0;
        @(posedge CLK);
        #1;

        // basic frame and two-cycle latency
        push(0, 16'd42, 8'd2, 1'b0, 1'b0);
        send(0, 8'd3, 8'd4, 1'b0);
        send(0, 8'd5, 8'd6, 1'b1);
        @(negedge CLK);
        chk("latency_k1_out_valid", {31'b0, if0.out_valid}, 32'd0);
        @(negedge CLK);
        chk("latency_k2_out_valid", {31'b0, if0.out_valid}, 32'd1);
        drain();

        // threshold exceed, then the tail of the frame
        if0.threshold = 16'd100;
        push(0, 16'd110, 8'd2, 1'b1, 1'b0);
        push(0, 16'd1, 8'd1, 1'b0, 1'b0);
        send(0, 8'd10, 8'd5, 1'b0);
        send(0, 8'd10, 8'd6, 1'b0);
        send(0, 8'd1, 8'd1, 1'b1);
        drain();
        if0.threshold = 16'hFFFF;

        // overflow: saturate vs wrap
        push(0, 16'hFFFF, 8'd2, 1'b0, 1'b1);
        send(0, 8'd255, 8'd255, 1'b0);
        send(0, 8'd255, 8'd255, 1'b1);
        push(1, 16'hFC02, 8'd2, 1'b0, 1'b1);
        send(1, 8'd255, 8'd255, 1'b0);
        send(1, 8'd255, 8'd255, 1'b1);
        drain();

        // back-pressure hold and release
        if0.out_ready = 1'b0;
        push(0, 16'd2, 8'd1, 1'b0, 1'b0);
        send(0, 8'd1, 8'd2, 1'b1);
        wait_valid(0);
        @(posedge CLK);
        #1;
        set_in(0, 1'b1, 8'd3, 8'd3, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("bp_in_ready", {31'b0, if0.in_ready}, 32'd0);
            chk("bp_hold", {15'b0, if0.out_valid, if0.a}, {15'b0, 1'b1, 16'd2});
            @(posedge CLK);
            #1;
        end
        if0.out_ready = 1'b1;
        push(0, 16'd9, 8'd1, 1'b0, 1'b0);
        @(negedge CLK);
        chk("release_in_ready", {31'b0, if0.in_ready}, 32'd1);
        @(posedge CLK);
        #1;
        send(0, 8'd1, 8'd1, 1'b0);
        chk("resume_rate_1", last_wait, 1);
        send(0, 8'd1, 8'd1, 1'b1);
        chk("resume_rate_2", last_wait, 1);
        push(0, 16'd2, 8'd2, 1'b0, 1'b0);
        drain();

        // signed, threshold at most-negative and most-positive
        if2.threshold = 16'h8000;
        push(2, 16'hFFEB, 8'd1, 1'b1, 1'b0);
        send(2, 8'hFD, 8'h07, 1'b1);
        drain();
        if2.threshold = 16'h7FFF;
        push(2, 16'hFFEB, 8'd1, 1'b0, 1'b0);
        send(2, 8'hFD, 8'h07, 1'b1);
        drain();

        // clear flushes accumulation and the in-flight sample
        send(0, 8'd1, 8'd1, 1'b0);
        send(0, 8'd1, 8'd1, 1'b0);
        send(0, 8'd1, 8'd1, 1'b0);
        if0.clear = 1'b1;
        @(negedge CLK);
        chk("clear_in_ready", {31'b0, if0.in_ready}, 32'd0);
        @(posedge CLK);
        #1;
        if0.clear = 1'b0;
        push(0, 16'd4, 8'd1, 1'b0, 1'b0);
        send(0, 8'd2, 8'd2, 1'b1);
        drain();

        // reset discards a pending result
        if0.out_ready = 1'b0;
        send(0, 8'd9, 8'd9, 1'b1);
        wait_valid(0);
        chk("pending_a", {16'b0, if0.a}, 32'd81);
        @(posedge CLK);
        #3;
        RESET = 1'b1;
        #1;
        chk("async_reset_pending", outs(0), 32'h0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        if0.out_ready = 1'b1;
        repeat (4) @(posedge CLK);
        #1;
        chk("no_stale_result", {31'b0, if0.out_valid}, 32'd0);

        // reset discards a partial accumulation
        send(0, 8'd5, 8'd5, 1'b0);
        #2;
        RESET = 1'b1;
        #1;
        chk("async_reset_accum", outs(0), 32'h0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        push(0, 16'd6, 8'd1, 1'b0, 1'b0);
        send(0, 8'd2, 8'd3, 1'b1);
        drain();

        chk("q0_empty", q0.size(), 0);
        chk("q1_empty", q1.size(), 0);
        chk("q2_empty", q2.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fmac_stream.md
Name: fmac_stream

Overview:
- Parametrised, pipelined multiply-accumulate unit; the next-generation replacement for the fixed 8x8/16-bit fmac.
- Accepts (x, y) sample pairs over a valid/ready stream and accumulates x*y with a selectable signed/unsigned mode and a selectable saturate/wrap mode.
- Emits a result on an output valid/ready stream when a frame ends (last) or when the running sum exceeds a programmable threshold.
- Sits between the sample source and the downstream detector logic.

Parameters:
- DATA_W, 8: width of x and y.
- ACC_W, 16: accumulator, threshold and result width. Must satisfy ACC_W >= 2*DATA_W.
- SIGNED, 0: 1 = x, y, threshold and accumulator are two's complement; 0 = unsigned.
- SATURATE, 1: 1 = clamp the accumulator at its range limits; 0 = wrap modulo 2^ACC_W.
- COUNT_W, 8: width of the sample counter.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- in_valid  in  1  sample present.
- in_ready  out  1  block can accept a sample.
- x  in  DATA_W  multiplicand.
- y  in  DATA_W  multiplier.
- last  in  1  sample closes the current frame.
- clear  in  1  synchronous flush of the accumulation.
- threshold  in  ACC_W  exceed limit, sampled every cycle.
- out_valid  out  1  result held in the output register.
- out_ready  in  1  consumer takes the result.
- a  out  ACC_W  result sum.
- out_count  out  COUNT_W  number of samples in the result.
- out_over  out  1  result was emitted because the sum exceeded threshold.
- out_ovf  out  1  overflow occurred during this accumulation.

Behaviour:
- Reset (asynchronous, active-high): stage-1 valid=0, acc=0, cnt=0, ovf flag=0, out_valid=0, a=0, out_count=0, out_over=0, out_ovf=0.
- Global enable: en = !(out_valid && !out_ready). in_ready = en && !clear. A handshake is in_valid && in_ready.
- Stage 1 (when en): registers the product p = x*y (2*DATA_W bits, signed or unsigned per SIGNED) plus a valid bit and the last bit. Stage-1 valid is set from the handshake.
- Stage 2 (when en and stage-1 valid):
  - p is sign- or zero-extended to ACC_W; sum = acc + p is computed in ACC_W+1 bits.
  - Overflow means the result is out of the ACC_W range (signed or unsigned per SIGNED).
  - SATURATE=1: clamp to max/min. SATURATE=0: keep the low ACC_W bits.
  - acc_next = the clamped/wrapped value; cnt_next = cnt+1, saturating at 2^COUNT_W-1; ovf_next = ovf | overflow.
  - exceed = acc_next > threshold (strict; signed compare when SIGNED=1).
  - If exceed or last: load a=acc_next, out_count=cnt_next, out_over=exceed, out_ovf=ovf_next; set out_valid=1; clear acc, cnt and ovf to 0.
  - Otherwise: acc=acc_next, cnt=cnt_next, ovf=ovf_next.
- Output register: out_valid clears when out_valid && out_ready and no new result loads that cycle. A new result may load in the same cycle the old one is consumed, giving back-to-back results.
- Latency: a sample handshaken in cycle k produces a result visible (out_valid=1) in cycle k+2. Throughput is 1 sample/cycle with no back-pressure.
- Back-pressure: while out_valid && !out_ready, stage 1 and stage 2 freeze and in_ready=0. a, out_count, out_over and out_ovf stay stable.
- clear=1:
  - Next edge: acc, cnt and ovf go to 0; stage-1 valid goes to 0 (in-flight sample dropped).
  - in_ready is 0 during the clear cycle.
  - The output register is untouched; a pending result is not lost.
  - clear takes priority over an emit in the same cycle: no result is produced.
- threshold changes take effect on the next stage-2 update; there is no retroactive emit.
- Reset asserted mid-operation: the immediate asynchronous return to the reset state above; the pending output is discarded.

Test Plan:
- Default params, threshold=0xFFFF; handshake (3,4,last=0), then (5,6,last=1) -> exactly one result 2 cycles after the second handshake: a=42, out_count=2, out_over=0, out_ovf=0.
- threshold=100; (10,5), (10,6), then (1,1,last=1) -> first result a=110, count=2, over=1; second result a=1, count=1, over=0.
- threshold=0xFFFF; (255,255), then (255,255,last=1) -> SATURATE=1: a=0xFFFF, ovf=1, count=2. Same stimulus with SATURATE=0: a=0xFC02, ovf=1.
- Result pending with out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0 throughout and a stays stable. Raise out_ready -> result taken; in_ready=1 the same cycle; a further sample resumes at 1/cycle.
- SIGNED=1; (0xFD,0x07,last=1) with threshold=0x8000 -> a=0xFFEB (-21), over=1 (since -21 > -32768). With threshold=0x7FFF -> over=0.
- Three samples accumulated, then clear=1 for one cycle, then (2,2,last=1) -> a=4, count=1. Separately: RESET pulsed between handshakes -> all outputs 0 asynchronously; no stale result after release.
